regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 33 +++
 rtl/regfile_write_arbiter.sv | 92 +++++++++
 tb/tb_regfile_write_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: write-back bus between the ALU/load producers, the arbiter and the register file
//   AluValid/AluReady/AluReg/AluData : ALU write-back request and its ready
//   MemValid/MemReady/MemReg/MemData : load write-back request and its ready
//   RegWrite/WriteRegister/WriteData : register-file write port driven by the arbiter
//   ReadRegister1/2, Pending1/2      : decode-stage hazard lookup and its answer
//   modport master: producer/decode side; modport slave: the arbiter
interface regfile_write_arbiter_if;
    logic        AluValid;
    logic        AluReady;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        MemValid;
    logic        MemReady;
    logic [4:0]  MemReg;
    logic [31:0] MemData;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic        Pending1;
    logic        Pending2;

    modport master (
        output AluValid, AluReg, AluData, MemValid, MemReg, MemData, ReadRegister1, ReadRegister2,
        input  AluReady, MemReady, RegWrite, WriteRegister, WriteData, Pending1, Pending2
    );

    modport slave (
        input  AluValid, AluReg, AluData, MemValid, MemReg, MemData, ReadRegister1, ReadRegister2,
        output AluReady, MemReady, RegWrite, WriteRegister, WriteData, Pending1, Pending2
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges ALU and load write-backs into one register-file write port
//   Clk   : clock, rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : regfile_write_arbiter_if.slave (requests, readies, write port, hazard lookup)
//   Each requester owns a 2-entry FIFO; one head is popped per edge, MEM first.
//   Define WB_STARVE_GUARD_EN to let ALU win after three MEM grants in a row.
module regfile_write_arbiter (
    input  logic Clk,
    input  logic Rst_n,
    regfile_write_arbiter_if.slave bus
);
    typedef logic [36:0] ent_t;

    // index 0 = ALU, 1 = MEM; slot 0 is the head
    ent_t       q   [2][2];
    logic [1:0] cnt [2];
    ent_t       din [2];
    logic [1:0] ne, push, pop;
    logic       rdy_en, alu_win, hit1, hit2;
    ent_t       head;

    assign din[0] = {bus.AluReg, bus.AluData};
    assign din[1] = {bus.MemReg, bus.MemData};
    // rdy_en keeps both readies low until the first edge after reset release
    assign bus.AluReady = rdy_en & (cnt[0] != 2'd2);
    assign bus.MemReady = rdy_en & (cnt[1] != 2'd2);
    assign push = {bus.MemValid & bus.MemReady, bus.AluValid & bus.AluReady};
    assign ne   = {cnt[1] != 2'd0, cnt[0] != 2'd0};

`ifdef WB_STARVE_GUARD_EN
    logic [1:0] starve;

    assign alu_win = ne[0] & (~ne[1] | (starve == 2'd3));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            starve <= 2'd0;
        else if (!ne[0] || alu_win)
            starve <= 2'd0;
        else
            starve <= starve + 2'd1;
    end
`else
    assign alu_win = ne[0] & ~ne[1];
`endif

    assign pop  = {ne[1] & ~alu_win, alu_win};
    assign head = alu_win ? q[0][0] : q[1][0];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rdy_en            <= 1'b0;
            bus.RegWrite      <= 1'b0;
            bus.WriteRegister <= 5'd0;
            bus.WriteData     <= 32'd0;
            for (int f = 0; f < 2; f++) begin
                cnt[f]  <= 2'd0;
                q[f][0] <= '0;
                q[f][1] <= '0;
            end
        end else begin
            rdy_en       <= 1'b1;
            // a popped reg-0 entry is consumed without a write strobe
            bus.RegWrite <= (|pop) & (head[36:32] != 5'd0);
            if (|pop) begin
                bus.WriteRegister <= head[36:32];
                bus.WriteData     <= head[31:0];
            end
            for (int f = 0; f < 2; f++) begin
                cnt[f] <= cnt[f] + {1'b0, push[f]} - {1'b0, pop[f]};
                if (pop[f])
                    q[f][0] <= q[f][1];
                // the new entry lands behind whatever survives the pop
                if (push[f])
                    q[f][(cnt[f] == 2'd1) && !pop[f]] <= din[f];
            end
        end
    end

    always_comb begin
        hit1 = bus.RegWrite && (bus.WriteRegister == bus.ReadRegister1);
        hit2 = bus.RegWrite && (bus.WriteRegister == bus.ReadRegister2);
        for (int f = 0; f < 2; f++) begin
            hit1 = hit1 || (ne[f] && q[f][0][36:32] == bus.ReadRegister1)
                        || (cnt[f] == 2'd2 && q[f][1][36:32] == bus.ReadRegister1);
            hit2 = hit2 || (ne[f] && q[f][0][36:32] == bus.ReadRegister2)
                        || (cnt[f] == 2'd2 && q[f][1][36:32] == bus.ReadRegister2);
        end
        bus.Pending1 = hit1 && (bus.ReadRegister1 != 5'd0);
        bus.Pending2 = hit2 && (bus.ReadRegister2 != 5'd0);
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table, arbitration-policy sequences and random traffic against a queue model
module tb_regfile_write_arbiter;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        ardy;
        logic        mrdy;
        logic        p1;
        logic        p2;
        logic        rw;
        logic        chkw;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    logic Clk;
    logic Rst_n;
    int   n_cmp;
    int   n_bad;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // behavioural model: two bounded queues, one grant per edge, MEM preferred
    ent_t        m_alu[$];
    ent_t        m_mem[$];
    bit          m_live;
    bit          m_rw;
    bit          m_known;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    int          m_streak;
    bit          ma_acc;
    bit          mm_acc;
    bit          m_got;
    ent_t        ma_ent;
    ent_t        mm_ent;
    ent_t        m_g;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_alu.delete();
            m_mem.delete();
            m_live   = 1'b0;
            m_rw     = 1'b0;
            m_known  = 1'b1;
            m_wr     = 5'd0;
            m_wd     = 32'd0;
            m_streak = 0;
        end else begin
            ma_acc = m_live && bus.AluValid && (m_alu.size() < 2);
            mm_acc = m_live && bus.MemValid && (m_mem.size() < 2);
            ma_ent = {bus.AluReg, bus.AluData};
            mm_ent = {bus.MemReg, bus.MemData};
            m_got  = 1'b1;
            if (m_mem.size() > 0 && !(GUARD && m_alu.size() > 0 && m_streak >= 3)) begin
                m_g      = m_mem.pop_front();
                m_streak = (m_alu.size() > 0) ? m_streak + 1 : 0;
            end else if (m_alu.size() > 0) begin
                m_g      = m_alu.pop_front();
                m_streak = 0;
            end else begin
                m_got    = 1'b0;
                m_streak = 0;
            end
            m_rw = m_got && (m_g.r != 5'd0);
            if (m_rw) begin
                m_wr    = m_g.r;
                m_wd    = m_g.d;
                m_known = 1'b1;
            end else if (m_got) begin
                m_known = 1'b0;
            end
            if (ma_acc) m_alu.push_back(ma_ent);
            if (mm_acc) m_mem.push_back(mm_ent);
            m_live = 1'b1;
        end
    end

    function automatic bit m_pend(input logic [4:0] rr);
        bit p;
        p = m_rw && (m_wr == rr);
        foreach (m_alu[i]) if (m_alu[i].r == rr) p = 1'b1;
        foreach (m_mem[i]) if (m_mem[i].r == rr) p = 1'b1;
        return p && (rr != 5'd0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.AluValid = 1'b0;
        bus.AluReg   = 5'd0;
        bus.AluData  = 32'd0;
        bus.MemValid = 1'b0;
        bus.MemReg   = 5'd0;
        bus.MemData  = 32'd0;
    endtask

    vec_t tbl[18];

    // both requesters stream six entries each; checks order and grant policy
    task automatic traffic();
        int   ai;
        int   mi;
        int   ap;
        int   mp;
        int   run;
        int   max_run;
        int   first_alu;
        int   last_mem;
        bit   a_acc;
        bit   m_acc;
        bit   order_ok;
        bit   policy_ok;
        ent_t w[$];
        ai = 0; mi = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.RegWrite) w.push_back({bus.WriteRegister, bus.WriteData});
            bus.AluValid = (ai < 6);
            bus.AluReg   = (ai % 2 != 0) ? 5'd2 : 5'd1;
            bus.AluData  = 32'hA0 + 32'(ai);
            bus.MemValid = (mi < 6);
            bus.MemReg   = (mi % 2 != 0) ? 5'd4 : 5'd3;
            bus.MemData  = 32'hB0 + 32'(mi);
            #1;
            a_acc = bus.AluValid && bus.AluReady;
            m_acc = bus.MemValid && bus.MemReady;
            @(posedge Clk);
            if (a_acc) ai++;
            if (m_acc) mi++;
            @(negedge Clk);
        end
        idle();
        ap = 0; mp = 0; run = 0; max_run = 0; first_alu = -1; last_mem = -1; order_ok = 1'b1;
        foreach (w[j]) begin
            if (w[j].r == 5'd1 || w[j].r == 5'd2) begin
                if (w[j].d != 32'hA0 + 32'(ap) || w[j].r != ((ap % 2 != 0) ? 5'd2 : 5'd1)) order_ok = 1'b0;
                ap++;
                if (first_alu < 0) first_alu = j;
                if (run > max_run) max_run = run;
                run = 0;
            end else begin
                if (w[j].d != 32'hB0 + 32'(mp) || w[j].r != ((mp % 2 != 0) ? 5'd4 : 5'd3)) order_ok = 1'b0;
                mp++;
                last_mem = j;
                run++;
            end
        end
        chk("traffic_count", w.size(), 12);
        chk("traffic_order", order_ok, 1);
        chk("traffic_first_is_mem", (w.size() > 0) ? w[0].r : 5'd0, 3);
        policy_ok = GUARD ? (first_alu == 3 && max_run <= 3) : (first_alu > last_mem);
        chk("traffic_policy", policy_ok, 1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Rst_n = 1'b0;
        idle();
        bus.ReadRegister1 = 5'd5;
        bus.ReadRegister2 = 5'd0;

        //          av ar  ad            mv mr  md            r1 r2  ardy mrdy p1 p2 rw chkw wr  wd
        tbl[0]  = '{0, 0,  0,            0, 0,  0,            5, 0,  0,   0,   0, 0, 0, 1,   0,  0};
        tbl[1]  = '{1, 5,  32'hDEADBEEF, 0, 0,  0,            5, 0,  1,   1,   0, 0, 0, 1,   0,  0};
        tbl[2]  = '{0, 0,  0,            0, 0,  0,            5, 0,  1,   1,   1, 0, 1, 1,   5,  32'hDEADBEEF};
        tbl[3]  = '{0, 0,  0,            0, 0,  0,            5, 0,  1,   1,   1, 0, 0, 1,   5,  32'hDEADBEEF};
        tbl[4]  = '{0, 0,  0,            0, 0,  0,            5, 0,  1,   1,   0, 0, 0, 1,   5,  32'hDEADBEEF};
        tbl[5]  = '{0, 0,  0,            1, 0,  32'h12345678, 0, 0,  1,   1,   0, 0, 0, 1,   5,  32'hDEADBEEF};
        tbl[6]  = '{0, 0,  0,            0, 0,  0,            0, 0,  1,   1,   0, 0, 0, 0,   0,  0};
        tbl[7]  = '{0, 0,  0,            1, 9,  32'h99,       0, 9,  1,   1,   0, 0, 0, 0,   0,  0};
        tbl[8]  = '{0, 0,  0,            0, 0,  0,            0, 9,  1,   1,   0, 1, 1, 1,   9,  32'h99};
        tbl[9]  = '{0, 0,  0,            0, 0,  0,            0, 9,  1,   1,   0, 1, 0, 1,   9,  32'h99};
        tbl[10] = '{1, 1,  32'h1,        1, 20, 32'h20,       2, 22, 1,   1,   0, 0, 0, 1,   9,  32'h99};
        tbl[11] = '{1, 2,  32'h2,        1, 21, 32'h21,       2, 22, 1,   1,   0, 0, 1, 1,   20, 32'h20};
        tbl[12] = '{1, 3,  32'h3,        1, 22, 32'h22,       2, 22, 0,   1,   1, 0, 1, 1,   21, 32'h21};
        tbl[13] = '{1, 3,  32'h3,        0, 0,  0,            2, 22, 0,   1,   1, 1, 1, 1,   22, 32'h22};
        tbl[14] = '{1, 3,  32'h3,        0, 0,  0,            2, 22, 0,   1,   1, 1, 1, 1,   1,  32'h1};
        tbl[15] = '{1, 3,  32'h3,        0, 0,  0,            2, 22, 1,   1,   1, 0, 1, 1,   2,  32'h2};
        tbl[16] = '{0, 0,  0,            0, 0,  0,            2, 22, 1,   1,   1, 0, 1, 1,   3,  32'h3};
        tbl[17] = '{0, 0,  0,            0, 0,  0,            2, 22, 1,   1,   0, 0, 0, 1,   3,  32'h3};

        repeat (2) @(negedge Clk);
        chk("rst_regwrite", bus.RegWrite, 0);
        chk("rst_wreg", bus.WriteRegister, 0);
        chk("rst_wdata", bus.WriteData, 0);
        chk("rst_alu_ready", bus.AluReady, 0);
        chk("rst_mem_ready", bus.MemReady, 0);
        chk("rst_pending1", bus.Pending1, 0);
        Rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            bus.AluValid      = tbl[i].av;
            bus.AluReg        = tbl[i].ar;
            bus.AluData       = tbl[i].ad;
            bus.MemValid      = tbl[i].mv;
            bus.MemReg        = tbl[i].mr;
            bus.MemData       = tbl[i].md;
            bus.ReadRegister1 = tbl[i].r1;
            bus.ReadRegister2 = tbl[i].r2;
            #1;
            chk($sformatf("v%0d_alu_ready", i), bus.AluReady, tbl[i].ardy);
            chk($sformatf("v%0d_mem_ready", i), bus.MemReady, tbl[i].mrdy);
            chk($sformatf("v%0d_pending1", i), bus.Pending1, tbl[i].p1);
            chk($sformatf("v%0d_pending2", i), bus.Pending2, tbl[i].p2);
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("v%0d_regwrite", i), bus.RegWrite, tbl[i].rw);
            if (tbl[i].chkw) begin
                chk($sformatf("v%0d_wreg", i), bus.WriteRegister, tbl[i].wr);
                chk($sformatf("v%0d_wdata", i), bus.WriteData, tbl[i].wd);
            end
        end
        idle();
        bus.ReadRegister1 = 5'd0;
        bus.ReadRegister2 = 5'd0;
        repeat (2) @(negedge Clk);

        traffic();

        // fill the ALU FIFO, then reset mid-cycle
        bus.AluValid = 1'b1; bus.AluReg = 5'd6; bus.AluData = 32'h66;
        bus.MemValid = 1'b1; bus.MemReg = 5'd8; bus.MemData = 32'h88;
        bus.ReadRegister1 = 5'd6;
        bus.ReadRegister2 = 5'd8;
        repeat (2) begin
            @(posedge Clk);
            @(negedge Clk);
        end
        chk("full_alu_ready", bus.AluReady, 0);
        chk("full_regwrite", bus.RegWrite, 1);
        chk("full_pending1", bus.Pending1, 1);
        #2 Rst_n = 1'b0;
        #1;
        chk("midrst_regwrite", bus.RegWrite, 0);
        chk("midrst_wreg", bus.WriteRegister, 0);
        chk("midrst_wdata", bus.WriteData, 0);
        chk("midrst_alu_ready", bus.AluReady, 0);
        chk("midrst_mem_ready", bus.MemReady, 0);
        chk("midrst_pending1", bus.Pending1, 0);
        chk("midrst_pending2", bus.Pending2, 0);
        @(posedge Clk);
        #1;
        chk("inrst_alu_ready", bus.AluReady, 0);
        chk("inrst_mem_ready", bus.MemReady, 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        idle();
        #1;
        chk("release_alu_ready", bus.AluReady, 0);
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk);
            @(negedge Clk);
            chk("post_rst_regwrite", bus.RegWrite, 0);
            chk("post_rst_alu_ready", bus.AluReady, 1);
            chk("post_rst_pending1", bus.Pending1, 0);
        end

        for (int c = 0; c < 400; c++) begin
            chk("rnd_regwrite", bus.RegWrite, m_rw);
            if (m_rw || m_known) begin
                chk("rnd_wreg", bus.WriteRegister, m_wr);
                chk("rnd_wdata", bus.WriteData, m_wd);
            end
            bus.AluValid      = ($urandom_range(3) != 0);
            bus.AluReg        = 5'($urandom_range(7));
            bus.AluData       = $urandom;
            bus.MemValid      = ($urandom_range(3) != 0);
            bus.MemReg        = 5'($urandom_range(7));
            bus.MemData       = $urandom;
            bus.ReadRegister1 = 5'($urandom_range(7));
            bus.ReadRegister2 = 5'($urandom_range(7));
            if ($urandom_range(79) == 0) begin
                Rst_n = 1'b0;
                #1;
                chk("rnd_rst_regwrite", bus.RegWrite, 0);
                chk("rnd_rst_alu_ready", bus.AluReady, 0);
                chk("rnd_rst_pending1", bus.Pending1, 0);
                @(posedge Clk);
                @(negedge Clk);
                Rst_n = 1'b1;
            end else begin
                #1;
                chk("rnd_alu_ready", bus.AluReady, m_live && (m_alu.size() < 2));
                chk("rnd_mem_ready", bus.MemReady, m_live && (m_mem.size() < 2));
                chk("rnd_pending1", bus.Pending1, m_pend(bus.ReadRegister1));
                chk("rnd_pending2", bus.Pending2, m_pend(bus.ReadRegister2));
                @(posedge Clk);
                @(negedge Clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
